// File: rtl/vga_timing_gen.sv
// vga_timing_gen: two-mode VGA timing generator (640x480@60 / 800x600@72) with mode switch at frame boundaries.
module vga_timing_gen #(
  parameter int CLK_DIV_M0 = 4,
  parameter int CLK_DIV_M1 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_sel,
  output logic [10:0] h_cnt,
  output logic [10:0] v_cnt,
  output logic        hsync,
  output logic        vsync,
  output logic        visible,
  output logic        pix_en,
  output logic        frame_end,
  output logic [10:0] h_visible,
  output logic [10:0] h_back_porch,
  output logic [10:0] v_visible,
  output logic [10:0] v_back_porch,
  output logic        active_mode
);
  logic [7:0]  dcnt, div;
  logic [10:0] h_sync, h_total, v_sync, v_total;
  logic        h_end, v_end;
  // h_back_porch / v_back_porch are the first visible column / line (sync + back porch)
  always_comb begin
    div          = active_mode ? 8'(CLK_DIV_M1) : 8'(CLK_DIV_M0);
    h_sync       = active_mode ? 11'd120 : 11'd96;
    h_back_porch = active_mode ? 11'd184 : 11'd144;
    h_visible    = active_mode ? 11'd800 : 11'd640;
    h_total      = active_mode ? 11'd1040 : 11'd800;
    v_sync       = active_mode ? 11'd6 : 11'd2;
    v_back_porch = active_mode ? 11'd29 : 11'd35;
    v_visible    = active_mode ? 11'd600 : 11'd480;
    v_total      = active_mode ? 11'd666 : 11'd525;
    pix_en       = dcnt == div - 8'd1;
    h_end        = h_cnt == h_total - 11'd1;
    v_end        = v_cnt == v_total - 11'd1;
    frame_end    = pix_en && h_end && v_end;
    hsync        = (h_cnt < h_sync) ? active_mode : !active_mode;
    vsync        = (v_cnt < v_sync) ? active_mode : !active_mode;
    visible      = h_cnt >= h_back_porch && h_cnt < h_back_porch + h_visible &&
                   v_cnt >= v_back_porch && v_cnt < v_back_porch + v_visible;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt        <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      active_mode <= mode_sel;
    end else begin
      dcnt <= pix_en ? 8'd0 : dcnt + 8'd1;
      if (pix_en) begin
        h_cnt <= h_end ? 11'd0 : h_cnt + 11'd1;
        if (h_end) v_cnt <= v_end ? 11'd0 : v_cnt + 11'd1;
      end
      if (frame_end) active_mode <= mode_sel;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of reset, divider, sync/visible decode, wraps and mode switching.
module tb_vga_timing_gen;
  logic        clk = 0, rst, mode_sel;
  logic [10:0] h_cnt, v_cnt, h_visible, h_back_porch, v_visible, v_back_porch;
  logic        hsync, vsync, visible, pix_en, frame_end, active_mode;
  int          n_tests = 0, n_fail = 0;

  vga_timing_gen dut (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .hsync(hsync), .vsync(vsync), .visible(visible), .pix_en(pix_en),
    .frame_end(frame_end), .h_visible(h_visible), .h_back_porch(h_back_porch),
    .v_visible(v_visible), .v_back_porch(v_back_porch), .active_mode(active_mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Jumps the counters to a chosen position so frame boundaries are reachable quickly
  task automatic set_hv(input logic [10:0] h, input logic [10:0] v);
    @(negedge clk);
    force dut.h_cnt = h;
    force dut.v_cnt = v;
    #1;
    release dut.h_cnt;
    release dut.v_cnt;
  endtask

  task automatic wait_at(input logic [10:0] h);
    bit found = 0;
    for (int n = 0; n < 5000 && !found; n++) begin
      @(negedge clk);
      found = pix_en && h_cnt == h;
    end
    check("wait_pix_en_at_h", 32'(found), 1);
  endtask

  initial begin
    rst = 1;
    mode_sel = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_h", h_cnt, 0);
    check("rst_v", v_cnt, 0);
    check("rst_visible", visible, 0);
    check("rst_pix_en", pix_en, 0);
    check("rst_frame_end", frame_end, 0);
    check("rst_hsync_m0", hsync, 0);
    check("rst_vsync_m0", vsync, 0);
    check("rst_mode", active_mode, 0);
    check("m0_hbp", h_back_porch, 144);
    check("m0_vbp", v_back_porch, 35);
    check("m0_hvis", h_visible, 640);
    check("m0_vvis", v_visible, 480);
    rst = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check("m0_pix_en_seq", pix_en, 32'(i % 4 == 3));
      check("m0_h_seq", h_cnt, 32'(i / 4));
    end
    wait_at(95);
    check("m0_hsync_95", hsync, 0);
    wait_at(96);
    check("m0_hsync_96", hsync, 1);
    set_hv(143, 35);
    check("m0_vis_143_35", visible, 0);
    wait_at(144);
    check("m0_vis_144_35", visible, 1);
    set_hv(783, 514);
    check("m0_vis_783_514", visible, 1);
    set_hv(784, 514);
    check("m0_vis_784_514", visible, 0);
    set_hv(200, 515);
    check("m0_vis_200_515", visible, 0);
    set_hv(0, 1);
    check("m0_vsync_1", vsync, 0);
    set_hv(0, 2);
    check("m0_vsync_2", vsync, 1);
    set_hv(799, 10);
    wait_at(799);
    check("m0_line_fe", frame_end, 0);
    @(negedge clk);
    check("m0_line_wrap_h", h_cnt, 0);
    check("m0_line_wrap_v", v_cnt, 11);
    // mode request mid-frame must wait for the frame boundary
    set_hv(790, 524);
    mode_sel = 1;
    @(negedge clk);
    check("sw_mode_hold", active_mode, 0);
    check("sw_hsync_hold", hsync, 1);
    wait_at(799);
    check("m0_frame_end", frame_end, 1);
    check("sw_mode_pre", active_mode, 0);
    @(negedge clk);
    check("sw_mode_post", active_mode, 1);
    check("sw_h0", h_cnt, 0);
    check("sw_v0", v_cnt, 0);
    check("sw_hsync_m1", hsync, 1);
    check("sw_vsync_m1", vsync, 1);
    check("sw_pix_en0", pix_en, 0);
    check("sw_frame_end0", frame_end, 0);
    check("m1_hbp", h_back_porch, 184);
    check("m1_vbp", v_back_porch, 29);
    check("m1_hvis", h_visible, 800);
    check("m1_vvis", v_visible, 600);
    @(negedge clk);
    check("m1_pix_en_div2", pix_en, 1);
    @(negedge clk);
    check("m1_h_adv", h_cnt, 1);
    set_hv(119, 5);
    check("m1_hsync_119", hsync, 1);
    check("m1_vsync_5", vsync, 1);
    set_hv(120, 6);
    check("m1_hsync_120", hsync, 0);
    check("m1_vsync_6", vsync, 0);
    set_hv(184, 29);
    check("m1_vis_184_29", visible, 1);
    set_hv(183, 29);
    check("m1_vis_183_29", visible, 0);
    set_hv(984, 628);
    check("m1_vis_984_628", visible, 0);
    set_hv(1038, 100);
    wait_at(1039);
    check("m1_line_fe", frame_end, 0);
    @(negedge clk);
    check("m1_line_wrap_h", h_cnt, 0);
    check("m1_line_wrap_v", v_cnt, 101);
    set_hv(1038, 665);
    mode_sel = 0;
    wait_at(1039);
    check("m1_frame_end", frame_end, 1);
    @(negedge clk);
    check("sw10_mode", active_mode, 0);
    check("sw10_h0", h_cnt, 0);
    check("sw10_v0", v_cnt, 0);
    check("sw10_hsync", hsync, 0);
    // reset mid-frame, loading mode 1
    set_hv(500, 300);
    mode_sel = 1;
    rst = 1;
    @(negedge clk);
    check("midrst_h", h_cnt, 0);
    check("midrst_v", v_cnt, 0);
    check("midrst_visible", visible, 0);
    check("midrst_pix_en", pix_en, 0);
    check("midrst_mode", active_mode, 1);
    check("midrst_hsync", hsync, 1);
    rst = 0;
    @(negedge clk);
    check("postrst_pix_en", pix_en, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
